// File: rtl/hid_ng.sv
// HID hub: decodes MCU command/payload bytes into keyboard matrix, mouse,
// joystick and numpad state, and reports synchronised DB9 port changes by interrupt.
module hid_ng #(
    parameter int NJOY = 2,
    parameter int NDB9 = 1,
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_in_strobe,
    input  logic                data_in_start,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    input  logic [6*NDB9-1:0]   db9_port,
    output logic                irq,
    input  logic                iack,
    output logic [8*NJOY-1:0]   joystick,
    output logic [8*NJOY-1:0]   joystick_ax,
    output logic [8*NJOY-1:0]   joystick_ay,
    output logic [8*NJOY-1:0]   extra_button,
    output logic [NJOY-1:0]     joystick_strobe,
    output logic [7:0]          numpad,
    output logic [1:0]          mouse_btns,
    output logic [7:0]          mouse_x,
    output logic [7:0]          mouse_y,
    output logic                mouse_strobe,
    input  logic [ROWS-1:0]     keyboard_matrix_out,
    output logic [COLS-1:0]     keyboard_matrix_in
);

    localparam logic [7:0] CMD_STATUS  = 8'h00;
    localparam logic [7:0] CMD_KEY     = 8'h01;
    localparam logic [7:0] CMD_MOUSE   = 8'h02;
    localparam logic [7:0] CMD_JOY     = 8'h03;
    localparam logic [7:0] CMD_DB9     = 8'h04;
    localparam logic [7:0] CMD_CAUSE   = 8'h05;
    localparam logic [7:0] CMD_RELEASE = 8'h06;
    // Unassigned opcode: payload bytes after reset fall through until a real start.
    localparam logic [7:0] CMD_NONE    = 8'hFF;
    localparam logic [7:0] NUMPAD_DEV  = 8'h80;
    localparam logic [7:0] STATUS_ID   = {4'(NJOY), 4'(NDB9)};

    logic [7:0]                cmd;
    logic [3:0]                idx;
    logic                      key_rel;
    logic [6:0]                key_row;
    logic [7:0]                joy_dev;
    logic                      irq_enable;
    logic [NDB9-1:0]           change_mask;
    logic [NDB9-1:0]           db9_change;
    logic [6*NDB9-1:0]         db9_s1;
    logic [6*NDB9-1:0]         db9_s2;
    logic [ROWS-1:0][COLS-1:0] key;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        db9_change = '0;
        for (int k = 0; k < NDB9; k++)
            db9_change[k] = |(db9_s1[6*k +: 6] ^ db9_s2[6*k +: 6]);
    end

    // Wired-AND of every row currently pulled low; idle columns read high.
    always_comb begin
        keyboard_matrix_in = '1;
        for (int r = 0; r < ROWS; r++)
            if (!keyboard_matrix_out[r])
                keyboard_matrix_in = keyboard_matrix_in & key[r];
    end

    // NOTE: state is updated with non-blocking assignments only; later assignments in the block override earlier defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd             <= CMD_NONE;
            idx             <= '0;
            key_rel         <= 1'b0;
            key_row         <= '0;
            joy_dev         <= '0;
            irq             <= 1'b0;
            irq_enable      <= 1'b0;
            change_mask     <= '0;
            db9_s1          <= db9_port;
            db9_s2          <= db9_port;
            // NOTE: the key array is a flop bank with a reset value, not a RAM; all keys start released.
            key             <= '1;
            data_out        <= '0;
            joystick        <= '0;
            joystick_ax     <= '0;
            joystick_ay     <= '0;
            extra_button    <= '0;
            joystick_strobe <= '0;
            numpad          <= '0;
            mouse_btns      <= '0;
            mouse_x         <= '0;
            mouse_y         <= '0;
            mouse_strobe    <= 1'b0;
        end else begin
            mouse_strobe    <= 1'b0;
            joystick_strobe <= '0;
            db9_s1          <= db9_port;
            db9_s2          <= db9_s1;
            change_mask     <= change_mask | db9_change;

            if (data_in_strobe && data_in_start) begin
                cmd <= data_in;
                idx <= '0;
            end else if (data_in_strobe) begin
                if (idx != 4'hF)
                    idx <= idx + 4'd1;
                case (cmd)
                    CMD_STATUS: begin
                        if (idx == 4'd0)      data_out <= 8'h02;
                        else if (idx == 4'd1) data_out <= STATUS_ID;
                    end
                    CMD_KEY: begin
                        if (idx == 4'd0) begin
                            {key_rel, key_row} <= data_in;
                        end else if (idx == 4'd1) begin
                            // Out-of-range row/column simply matches no cell.
                            for (int r = 0; r < ROWS; r++)
                                for (int c = 0; c < COLS; c++)
                                    if (key_row == 7'(r) && data_in == 8'(c))
                                        key[r][c] <= key_rel;
                        end
                    end
                    CMD_MOUSE: begin
                        if (idx == 4'd0)      mouse_btns <= data_in[1:0];
                        else if (idx == 4'd1) mouse_x    <= data_in;
                        else if (idx == 4'd2) begin
                            mouse_y      <= data_in;
                            mouse_strobe <= 1'b1;
                        end
                    end
                    CMD_JOY: begin
                        if (idx == 4'd0) begin
                            joy_dev <= data_in;
                        end else begin
                            if (joy_dev == NUMPAD_DEV && idx == 4'd1)
                                numpad <= data_in;
                            for (int d = 0; d < NJOY; d++) begin
                                if (joy_dev == 8'(d)) begin
                                    case (idx)
                                        4'd1: joystick[8*d +: 8]     <= data_in;
                                        4'd2: joystick_ax[8*d +: 8]  <= data_in;
                                        4'd3: joystick_ay[8*d +: 8]  <= data_in;
                                        4'd4: begin
                                            extra_button[8*d +: 8] <= data_in;
                                            joystick_strobe[d]     <= 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                    CMD_DB9: begin
                        data_out <= 8'h00;
                        for (int k = 0; k < NDB9; k++)
                            if (idx == 4'(k))
                                data_out <= {2'b00, db9_s2[6*k +: 6]};
                        if (idx == 4'd0)
                            irq_enable <= 1'b1;
                    end
                    CMD_CAUSE: begin
                        if (idx == 4'd0) begin
                            data_out    <= 8'(change_mask);
                            change_mask <= db9_change;
                        end
                    end
                    CMD_RELEASE: begin
                        if (idx == 4'd0)
                            key <= '1;
                    end
                    default: ;
                endcase
            end

            // A fresh interrupt takes priority over an acknowledge in the same cycle.
            if (|db9_change && irq_enable) begin
                irq        <= 1'b1;
                irq_enable <= 1'b0;
            end else if (iack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hid_ng.sv
// Scoreboard bench for hid_ng: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares when the DUT strobes or a probe is raised.
module tb_hid_ng;

    localparam int NJOY = 2;
    localparam int NDB9 = 1;
    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              data_in_strobe = 1'b0;
    logic              data_in_start = 1'b0;
    logic [7:0]        data_in = '0;
    logic [7:0]        data_out;
    logic [6*NDB9-1:0] db9_port = 6'h2A;
    logic              irq;
    logic              iack = 1'b0;
    logic [8*NJOY-1:0] joystick, joystick_ax, joystick_ay, extra_button;
    logic [NJOY-1:0]   joystick_strobe;
    logic [7:0]        numpad;
    logic [1:0]        mouse_btns;
    logic [7:0]        mouse_x, mouse_y;
    logic              mouse_strobe;
    logic [ROWS-1:0]   keyboard_matrix_out = '1;
    logic [COLS-1:0]   keyboard_matrix_in;

    hid_ng #(.NJOY(NJOY), .NDB9(NDB9), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset(reset),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
        .data_in(data_in), .data_out(data_out),
        .db9_port(db9_port), .irq(irq), .iack(iack),
        .joystick(joystick), .joystick_ax(joystick_ax), .joystick_ay(joystick_ay),
        .extra_button(extra_button), .joystick_strobe(joystick_strobe),
        .numpad(numpad), .mouse_btns(mouse_btns), .mouse_x(mouse_x),
        .mouse_y(mouse_y), .mouse_strobe(mouse_strobe),
        .keyboard_matrix_out(keyboard_matrix_out),
        .keyboard_matrix_in(keyboard_matrix_in)
    );

    always #5 clk = ~clk;

    typedef enum {S_DOUT, S_MATRIX, S_IRQ, S_NUMPAD, S_MOUSE, S_JOY0, S_JOY1} sel_e;
    typedef struct { string name; sel_e sel; logic [39:0] val; } exp_t;
    typedef struct { logic [NJOY-1:0] strobe; int dev; logic [31:0] fields; } joy_t;

    exp_t        exp_q[$];
    logic [17:0] mouse_q[$];
    joy_t        joy_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        probe = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] read_sel(input sel_e s);
        case (s)
            S_DOUT:   return 40'(data_out);
            S_MATRIX: return 40'(keyboard_matrix_in);
            S_IRQ:    return 40'(irq);
            S_NUMPAD: return 40'(numpad);
            S_MOUSE:  return 40'({mouse_btns, mouse_x, mouse_y});
            S_JOY0:   return 40'({joystick[7:0], joystick_ax[7:0], joystick_ay[7:0], extra_button[7:0]});
            S_JOY1:   return 40'({joystick[15:8], joystick_ax[15:8], joystick_ay[15:8], extra_button[15:8]});
            default:  return '0;
        endcase
    endfunction

    // Monitor: compares probed values and every strobe the DUT emits.
    always @(negedge clk) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                check("probe_underflow", 48'd1, 48'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, 48'(read_sel(e.sel)), 48'(e.val));
            end
        end
        if (mouse_strobe) begin
            if (mouse_q.size() == 0)
                check("mouse_strobe_unexpected", 48'd1, 48'd0);
            else
                check("mouse_strobe_data", 48'({mouse_btns, mouse_x, mouse_y}), 48'(mouse_q.pop_front()));
        end
        if (|joystick_strobe) begin
            if (joy_q.size() == 0) begin
                check("joy_strobe_unexpected", 48'(joystick_strobe), 48'd0);
            end else begin
                joy_t j;
                j = joy_q.pop_front();
                check("joy_strobe_data",
                      48'({joystick_strobe, joystick[8*j.dev +: 8], joystick_ax[8*j.dev +: 8],
                           joystick_ay[8*j.dev +: 8], extra_button[8*j.dev +: 8]}),
                      48'({j.strobe, j.fields}));
            end
        end
    end

    task automatic send(input logic start, input logic [7:0] b);
        data_in_strobe = 1'b1;
        data_in_start  = start;
        data_in        = b;
        @(posedge clk); #1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
    endtask

    task automatic expect_now(input string name, input sel_e s, input logic [39:0] v);
        exp_q.push_back('{name: name, sel: s, val: v});
        probe = 1'b1;
        @(negedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key_cmd(input logic [7:0] b0, input logic [7:0] b1);
        send(1'b1, 8'h01);
        send(1'b0, b0);
        send(1'b0, b1);
    endtask

    task automatic wait_irq();
        for (int i = 0; i < 4 && !irq; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        keyboard_matrix_out = '0;
        expect_now("reset_matrix", S_MATRIX, 40'hFF);
        keyboard_matrix_out = '1;
        expect_now("reset_dout", S_DOUT, 40'h00);
        expect_now("reset_irq", S_IRQ, 40'h0);
        expect_now("reset_numpad", S_NUMPAD, 40'h00);
        expect_now("reset_mouse", S_MOUSE, 40'h0);
        expect_now("reset_joy1", S_JOY1, 40'h0);

        // Payload before any start is ignored
        send(1'b0, 8'h55);
        expect_now("orphan_payload", S_DOUT, 40'h00);

        // Status
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        expect_now("status_b0", S_DOUT, 40'h02);
        send(1'b0, 8'h00);
        expect_now("status_b1", S_DOUT, 40'h21);
        send(1'b0, 8'h00);
        expect_now("status_b2_hold", S_DOUT, 40'h21);

        // Key matrix
        key_cmd(8'h03, 8'h05);
        keyboard_matrix_out = 8'hF7;
        expect_now("key_press_r3c5", S_MATRIX, 40'hDF);
        keyboard_matrix_out = 8'hFE;
        expect_now("key_other_row", S_MATRIX, 40'hFF);
        key_cmd(8'h83, 8'h05);
        keyboard_matrix_out = 8'hF7;
        expect_now("key_release_r3c5", S_MATRIX, 40'hFF);
        key_cmd(8'h00, 8'h00);
        key_cmd(8'h07, 8'h07);
        keyboard_matrix_out = 8'h7E;
        expect_now("key_rows_0_7", S_MATRIX, 40'h7E);
        key_cmd(8'h09, 8'h01);
        key_cmd(8'h02, 8'h08);
        keyboard_matrix_out = 8'h00;
        expect_now("key_out_of_range", S_MATRIX, 40'h7E);
        send(1'b1, 8'h06);
        send(1'b0, 8'h00);
        expect_now("release_all_rows", S_MATRIX, 40'hFF);
        keyboard_matrix_out = 8'hF7;
        expect_now("release_all_r3", S_MATRIX, 40'hFF);
        keyboard_matrix_out = 8'hFF;
        expect_now("matrix_undriven", S_MATRIX, 40'hFF);

        // Mouse
        send(1'b1, 8'h02);
        send(1'b0, 8'h03);
        send(1'b0, 8'h10);
        mouse_q.push_back({2'b11, 8'h10, 8'hF0});
        send(1'b0, 8'hF0);
        expect_now("mouse_fields", S_MOUSE, 40'({2'b11, 8'h10, 8'hF0}));

        // Abort mouse command with a new start
        send(1'b1, 8'h02);
        send(1'b0, 8'h01);
        send(1'b0, 8'h10);
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        expect_now("abort_status", S_DOUT, 40'h02);
        expect_now("abort_mouse", S_MOUSE, 40'({2'b01, 8'h10, 8'hF0}));

        // Reset mid-command
        send(1'b1, 8'h02);
        send(1'b0, 8'h01);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        send(1'b0, 8'h44);
        expect_now("midreset_mouse", S_MOUSE, 40'h0);
        expect_now("midreset_dout", S_DOUT, 40'h00);

        // Joystick device 1
        send(1'b1, 8'h03);
        send(1'b0, 8'h01);
        send(1'b0, 8'h1F);
        send(1'b0, 8'h40);
        send(1'b0, 8'hC0);
        joy_q.push_back('{strobe: 2'b10, dev: 1, fields: 32'h1F40C003});
        send(1'b0, 8'h03);
        expect_now("joy1_fields", S_JOY1, 40'h1F40C003);
        expect_now("joy0_untouched", S_JOY0, 40'h0);

        // Joystick device 0
        send(1'b1, 8'h03);
        send(1'b0, 8'h00);
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        send(1'b0, 8'hCC);
        joy_q.push_back('{strobe: 2'b01, dev: 0, fields: 32'hAABBCCDD});
        send(1'b0, 8'hDD);
        expect_now("joy1_after_dev0", S_JOY1, 40'h1F40C003);

        // Numpad and invalid device
        send(1'b1, 8'h03);
        send(1'b0, 8'h80);
        send(1'b0, 8'h5A);
        send(1'b0, 8'h77);
        expect_now("numpad", S_NUMPAD, 40'h5A);
        send(1'b1, 8'h03);
        send(1'b0, 8'h05);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        send(1'b0, 8'h44);
        expect_now("baddev_joy0", S_JOY0, 40'hAABBCCDD);
        expect_now("baddev_joy1", S_JOY1, 40'h1F40C003);
        expect_now("baddev_numpad", S_NUMPAD, 40'h5A);

        // DB9 read and interrupt
        send(1'b1, 8'h04);
        send(1'b0, 8'h00);
        expect_now("db9_port0", S_DOUT, 40'h2A);
        send(1'b0, 8'h00);
        expect_now("db9_port1_absent", S_DOUT, 40'h00);
        db9_port = db9_port ^ 6'h04;
        wait_irq();
        expect_now("db9_irq_set", S_IRQ, 40'h1);
        iack = 1'b1;
        @(posedge clk); #1;
        iack = 1'b0;
        expect_now("iack_clears", S_IRQ, 40'h0);
        db9_port = db9_port ^ 6'h01;
        idle(4);
        expect_now("no_rearm_irq", S_IRQ, 40'h0);
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        expect_now("cause_mask", S_DOUT, 40'h01);
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        expect_now("cause_cleared", S_DOUT, 40'h00);

        // Change arriving in the same cycle as the cause read survives
        db9_port = db9_port ^ 6'h20;
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        expect_now("cause_race_read", S_DOUT, 40'h00);
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        expect_now("cause_race_kept", S_DOUT, 40'h01);

        // irq/iack collision
        send(1'b1, 8'h04);
        send(1'b0, 8'h00);
        expect_now("db9_port0_again", S_DOUT, 40'h0F);
        db9_port = db9_port ^ 6'h08;
        wait_irq();
        expect_now("db9_irq_set2", S_IRQ, 40'h1);
        send(1'b1, 8'h04);
        send(1'b0, 8'h00);
        db9_port = db9_port ^ 6'h02;
        @(posedge clk); #1;
        iack = 1'b1;
        @(posedge clk); #1;
        iack = 1'b0;
        expect_now("collision_set_wins", S_IRQ, 40'h1);
        iack = 1'b1;
        @(posedge clk); #1;
        iack = 1'b0;
        expect_now("collision_then_iack", S_IRQ, 40'h0);

        // Final status
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        expect_now("final_status_b0", S_DOUT, 40'h02);
        send(1'b0, 8'h00);
        expect_now("final_status_b1", S_DOUT, 40'h21);

        idle(3);
        check("scoreboard_drained", 48'(exp_q.size() + mouse_q.size() + joy_q.size()), 48'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
